// File: rtl/iq_nco_pkg.sv
// Shared constants and elaboration-time helpers for the quadrature NCO.
package iq_nco_pkg;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_e;

  // Q30 fixed point keeps the table generator in pure integer arithmetic
  localparam longint ONE_Q = 64'sd1073741824;
  localparam longint PI_Q  = 64'sd3373259426;

  function automatic int unsigned amp(input int unsigned data_w);
    return (32'd1 << (data_w - 32'd1)) - 32'd1;
  endfunction

  function automatic int unsigned zero_code(input int unsigned data_w, input bit offset_bin);
    return offset_bin ? (32'd1 << (data_w - 32'd1)) : 32'd0;
  endfunction

  // round(a * sin(pi/2 * k/n)) via an odd Taylor series up to x^15
  function automatic int unsigned qtab_entry(input int unsigned k, input int unsigned n,
                                             input int unsigned a);
    longint kk, nn, aa, x, x2, term, s, r;
    kk   = longint'(k);
    nn   = longint'(n);
    aa   = longint'(a);
    x    = (PI_Q * kk) / (64'sd2 * nn);
    x2   = (x * x) / ONE_Q;
    term = x;
    s    = x;
    for (int j = 1; j < 8; j++) begin
      term = -((term * x2) / ONE_Q) / longint'((2 * j) * (2 * j + 1));
      s    = s + term;
    end
    r = (aa * s + ONE_Q / 64'sd2) / ONE_Q;
    return 32'(r);
  endfunction

endpackage

// File: rtl/nco_qlut.sv
// Quarter-wave sine ROM (N+1 entries) with two combinational read ports.
module nco_qlut
  import iq_nco_pkg::*;
#(
  parameter int unsigned LUT_AW = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic [LUT_AW-2:0] idx_a,
  input  logic [LUT_AW-2:0] idx_b,
  output logic [DATA_W-2:0] mag_a_c,
  output logic [DATA_W-2:0] mag_b_c
);

  localparam int unsigned N  = 32'd1 << (LUT_AW - 32'd2);
  localparam int unsigned QW = DATA_W - 32'd1;
  localparam int unsigned A  = amp(DATA_W);

  logic [QW-1:0] rom [N+1];

  for (genvar k = 0; k <= int'(N); k++) begin : g_rom
    assign rom[k] = QW'(qtab_entry(32'(k), N, A));
  end

  assign mag_a_c = rom[idx_a];
  assign mag_b_c = rom[idx_b];

endmodule

// File: rtl/iq_nco.sv
// Quadrature NCO: phase accumulator, folded quarter-wave lookup, 3-stage valid-tagged pipe.
module iq_nco
  import iq_nco_pkg::*;
#(
  parameter int unsigned PHASE_W    = 24,
  parameter int unsigned LUT_AW     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter bit          OFFSET_BIN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic               freq_load,
  input  logic [LUT_AW-1:0]  phase_off,
  input  logic               sync_clr,
  output logic [DATA_W-1:0]  sin_out,
  output logic [DATA_W-1:0]  cos_out,
  output logic               out_valid
);

  localparam int unsigned N  = 32'd1 << (LUT_AW - 32'd2);
  localparam int unsigned IW = LUT_AW - 32'd1;
  localparam logic [DATA_W-1:0] ZERO = DATA_W'(zero_code(DATA_W, OFFSET_BIN));
  localparam logic [DATA_W-1:0] MSB  = {1'b1, {(DATA_W - 1){1'b0}}};

  logic [PHASE_W-1:0] acc, freq_act;
  logic [LUT_AW-1:0]  addr_s, addr_c, addr_nxt_c;
  logic [IW-1:0]      idx_s_c, idx_c_c;
  logic [DATA_W-2:0]  mag_s_c, mag_c_c;
  logic [DATA_W-1:0]  val_s, val_c;
  logic               v1, v2;

  // Mirror index for the odd quadrants so Q[N-i] covers the descending half
  function automatic logic [IW-1:0] fold_idx(input logic [LUT_AW-1:0] a);
    quad_e         q;
    logic [IW-1:0] i;
    q = quad_e'(a[LUT_AW-1 -: 2]);
    i = IW'(a[LUT_AW-3:0]);
    return (q == QUAD_1 || q == QUAD_3) ? (IW'(N) - i) : i;
  endfunction

  function automatic logic [DATA_W-1:0] sign_mag(input logic [LUT_AW-1:0] a,
                                                 input logic [DATA_W-2:0] m);
    logic [DATA_W-1:0] e;
    quad_e             q;
    e = {1'b0, m};
    q = quad_e'(a[LUT_AW-1 -: 2]);
    return (q == QUAD_2 || q == QUAD_3) ? (~e + DATA_W'(1)) : e;
  endfunction

  function automatic logic [DATA_W-1:0] fmt(input logic [DATA_W-1:0] v);
    return OFFSET_BIN ? (v ^ MSB) : v;
  endfunction

  assign addr_nxt_c = acc[PHASE_W-1 -: LUT_AW] + phase_off;
  assign idx_s_c    = fold_idx(addr_s);
  assign idx_c_c    = fold_idx(addr_c);

  nco_qlut #(
    .LUT_AW (LUT_AW),
    .DATA_W (DATA_W)
  ) u_qlut (
    .idx_a   (idx_s_c),
    .idx_b   (idx_c_c),
    .mag_a_c (mag_s_c),
    .mag_b_c (mag_c_c)
  );

  // Phase accumulator and active tuning word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      freq_act <= '0;
    end else begin
      if (sync_clr)  acc <= '0;
      else if (en)   acc <= acc + freq_act;
      if (freq_load) freq_act <= freq_word;
    end
  end

  // Stage 1: lookup addresses from the pre-increment phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_s <= '0;
      addr_c <= '0;
      v1     <= 1'b0;
    end else begin
      v1 <= en;
      if (en) begin
        addr_s <= addr_nxt_c;
        addr_c <= addr_nxt_c + LUT_AW'(N);
      end
    end
  end

  // Stage 2: folded table read with quadrant sign
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_s <= '0;
      val_c <= '0;
      v2    <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        val_s <= sign_mag(addr_s, mag_s_c);
        val_c <= sign_mag(addr_c, mag_c_c);
      end
    end
  end

  // Stage 3: output format; samples hold between valid pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sin_out   <= ZERO;
      cos_out   <= ZERO;
      out_valid <= 1'b0;
    end else begin
      out_valid <= v2;
      if (v2) begin
        sin_out <= fmt(val_s);
        cos_out <= fmt(val_c);
      end
    end
  end

endmodule

// File: tb/tb_iq_nco.sv
// Scoreboard bench for iq_nco: offset-binary and two's-complement instances driven in parallel.
module tb_iq_nco;

  localparam int unsigned PHASE_W = 24;
  localparam int unsigned LUT_AW  = 8;
  localparam int unsigned DATA_W  = 8;
  localparam int          NQ      = 64;
  localparam int          AMP     = 127;

  logic        clk = 1'b0;
  logic        rst_n, en, freq_load, sync_clr;
  logic [23:0] freq_word;
  logic [7:0]  phase_off;
  logic [7:0]  sin_ob, cos_ob, sin_tc, cos_tc;
  logic        vld_ob, vld_tc;

  always #5 clk = ~clk;

  iq_nco #(.PHASE_W(PHASE_W), .LUT_AW(LUT_AW), .DATA_W(DATA_W), .OFFSET_BIN(1'b1)) dut_ob (
    .clk(clk), .rst_n(rst_n), .en(en), .freq_word(freq_word), .freq_load(freq_load),
    .phase_off(phase_off), .sync_clr(sync_clr), .sin_out(sin_ob), .cos_out(cos_ob),
    .out_valid(vld_ob));

  iq_nco #(.PHASE_W(PHASE_W), .LUT_AW(LUT_AW), .DATA_W(DATA_W), .OFFSET_BIN(1'b0)) dut_tc (
    .clk(clk), .rst_n(rst_n), .en(en), .freq_word(freq_word), .freq_load(freq_load),
    .phase_off(phase_off), .sync_clr(sync_clr), .sin_out(sin_tc), .cos_out(cos_tc),
    .out_valid(vld_tc));

  typedef struct {
    int         due;
    logic [7:0] s_ob, c_ob, s_tc, c_tc;
  } exp_t;

  exp_t        sb[$];
  exp_t        last;
  logic [7:0]  obs_s[$], obs_c[$], obs_stc[$], run_a_cos[$];
  int          n_vec = 0, n_err = 0, edge_n = 0;
  logic [23:0] m_acc, m_freq;

  logic [7:0] q_sin [4] = '{8'h80, 8'hFF, 8'h80, 8'h01};
  logic [7:0] q_cos [4] = '{8'hFF, 8'h80, 8'h01, 8'h80};
  logic [7:0] q_stc [4] = '{8'h00, 8'h7F, 8'h00, 8'h81};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got 0x%0h expected 0x%0h", tag, edge_n, got, exp);
    end
  endtask

  function automatic int qtab(input int k);
    real r;
    r = 3.14159265358979 * real'(k) / (2.0 * real'(NQ));
    return $rtoi(real'(AMP) * $sin(r) + 0.5);
  endfunction

  // Signed sample value for an 8-bit lookup address
  function automatic int sval(input int a);
    int q, i, m;
    q = a / NQ;
    i = a % NQ;
    m = (q == 1 || q == 3) ? qtab(NQ - i) : qtab(i);
    return (q >= 2) ? -m : m;
  endfunction

  function automatic logic [7:0] to_ob(input int v);
    return 8'(v + 128);
  endfunction

  function automatic logic [7:0] to_tc(input int v);
    return 8'(v);
  endfunction

  task automatic monitor();
    bit   exp_v;
    exp_t e;
    exp_v = (sb.size() > 0) && (sb[0].due == edge_n);
    check("valid_ob", 32'(vld_ob), 32'(exp_v));
    check("valid_tc", 32'(vld_tc), 32'(exp_v));
    if (exp_v) begin
      e    = sb.pop_front();
      last = e;
      obs_s.push_back(sin_ob);
      obs_c.push_back(cos_ob);
      obs_stc.push_back(sin_tc);
    end
    check("sin_ob", 32'(sin_ob), 32'(last.s_ob));
    check("cos_ob", 32'(cos_ob), 32'(last.c_ob));
    check("sin_tc", 32'(sin_tc), 32'(last.s_tc));
    check("cos_tc", 32'(cos_tc), 32'(last.c_tc));
  endtask

  task automatic cycle(input bit e, input logic [23:0] fw, input bit fl,
                       input logic [7:0] po, input bit clr);
    exp_t x;
    int   a, ac;
    en = e; freq_word = fw; freq_load = fl; phase_off = po; sync_clr = clr;
    if (e) begin
      a      = (int'(m_acc[23:16]) + int'(po)) & 255;
      ac     = (a + NQ) & 255;
      x.due  = edge_n + 3;
      x.s_ob = to_ob(sval(a));
      x.c_ob = to_ob(sval(ac));
      x.s_tc = to_tc(sval(a));
      x.c_tc = to_tc(sval(ac));
      sb.push_back(x);
    end
    if (clr)    m_acc = '0;
    else if (e) m_acc = m_acc + m_freq;
    if (fl)     m_freq = fw;
    @(posedge clk);
    edge_n++;
    #1;
    monitor();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 24'h0, 1'b0, 8'h0, 1'b0);
  endtask

  task automatic reset_hold(input int n);
    rst_n = 1'b0; en = 1'b1; freq_word = 24'h123456; freq_load = 1'b1;
    phase_off = 8'h11; sync_clr = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      edge_n++;
      #1;
      check("rst_valid_ob", 32'(vld_ob), 32'h0);
      check("rst_valid_tc", 32'(vld_tc), 32'h0);
      check("rst_sin_ob", 32'(sin_ob), 32'h80);
      check("rst_cos_ob", 32'(cos_ob), 32'h80);
      check("rst_sin_tc", 32'(sin_tc), 32'h00);
      check("rst_cos_tc", 32'(cos_tc), 32'h00);
    end
    en = 1'b0; freq_load = 1'b0; phase_off = 8'h0;
    rst_n = 1'b1;
    sb.delete();
    m_acc = '0; m_freq = '0;
    last.s_ob = 8'h80; last.c_ob = 8'h80; last.s_tc = 8'h00; last.c_tc = 8'h00;
  endtask

  initial begin
    reset_hold(3);

    // Quarter step: four samples at 90 degree spacing
    cycle(1'b0, 24'h400000, 1'b1, 8'h0, 1'b0);
    obs_s.delete(); obs_c.delete(); obs_stc.delete();
    for (int i = 0; i < 4; i++) cycle(1'b1, 24'h0, 1'b0, 8'h0, 1'b0);
    drain(3);
    check("qstep_count", 32'(obs_s.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("qstep_sin", 32'(obs_s[i]), 32'(q_sin[i]));
      check("qstep_cos", 32'(obs_c[i]), 32'(q_cos[i]));
      check("qstep_sin_tc", 32'(obs_stc[i]), 32'(q_stc[i]));
    end

    // Full address sweep, zero offset then 90 degree offset
    cycle(1'b0, 24'h010000, 1'b1, 8'h0, 1'b1);
    obs_c.delete();
    for (int i = 0; i < 300; i++) cycle(1'b1, 24'h0, 1'b0, 8'h00, 1'b0);
    drain(3);
    run_a_cos = obs_c;
    cycle(1'b0, 24'h0, 1'b0, 8'h0, 1'b1);
    obs_s.delete();
    for (int i = 0; i < 300; i++) cycle(1'b1, 24'h0, 1'b0, 8'h40, 1'b0);
    drain(3);
    check("sweep_count", 32'(obs_s.size()), 32'd300);
    for (int i = 0; i < 300; i++)
      check("offset_sin_vs_cos", 32'(obs_s[i]), 32'(run_a_cos[i]));

    // Gated strobe 1,0,0,1
    cycle(1'b0, 24'h400000, 1'b1, 8'h0, 1'b1);
    obs_s.delete();
    cycle(1'b1, 24'h0, 1'b0, 8'h0, 1'b0);
    cycle(1'b0, 24'h0, 1'b0, 8'h0, 1'b0);
    cycle(1'b0, 24'h0, 1'b0, 8'h0, 1'b0);
    cycle(1'b1, 24'h0, 1'b0, 8'h0, 1'b0);
    drain(4);
    check("gated_pulses", 32'(obs_s.size()), 32'd2);

    // sync_clr + freq_load together with en
    obs_s.delete(); obs_c.delete();
    cycle(1'b1, 24'h0, 1'b0, 8'h0, 1'b0);
    cycle(1'b1, 24'h800000, 1'b1, 8'h0, 1'b1);
    cycle(1'b1, 24'h0, 1'b0, 8'h0, 1'b0);
    cycle(1'b1, 24'h0, 1'b0, 8'h0, 1'b0);
    drain(3);
    check("simul_count", 32'(obs_s.size()), 32'd4);
    check("simul_sin0", 32'(obs_s[2]), 32'h80);
    check("simul_sin1", 32'(obs_s[3]), 32'h80);
    check("simul_cos0", 32'(obs_c[2]), 32'hFF);
    check("simul_cos1", 32'(obs_c[3]), 32'h01);

    // Random mix of strobes, offsets, loads and clears
    for (int i = 0; i < 200; i++)
      cycle(1'($urandom_range(0, 3) != 0), 24'($urandom), 1'($urandom_range(0, 15) == 0),
            8'($urandom), 1'($urandom_range(0, 31) == 0));
    drain(3);

    // Asynchronous reset mid-cycle flushes samples in flight
    cycle(1'b1, 24'h0, 1'b0, 8'h40, 1'b0);
    cycle(1'b1, 24'h0, 1'b0, 8'h00, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_valid", 32'(vld_ob), 32'h0);
    check("async_sin_ob", 32'(sin_ob), 32'h80);
    check("async_cos_ob", 32'(cos_ob), 32'h80);
    check("async_sin_tc", 32'(sin_tc), 32'h00);
    @(posedge clk);
    edge_n++;
    #1;
    reset_hold(1);
    drain(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
